// File: rtl/rep_iter_ctrl.sv
// REP string-instruction sequencer: issues the first iteration combinationally,
// then replays from registered addresses/count until the count is exhausted.
module rep_iter_ctrl (
  input  logic        clk,
  input  logic        clr,
  input  logic        valid_in,
  input  logic        is_rep,
  input  logic [31:0] count_in,
  input  logic        addrmode,
  input  logic [31:0] addr1_in,
  input  logic [31:0] addr2_in,
  input  logic [1:0]  opsize,
  input  logic        dflag,
  input  logic        advance,
  input  logic        flush,
  output logic [31:0] mem_addr1,
  output logic [31:0] mem_addr2,
  output logic        iter_valid,
  output logic        rep_stall,
  output logic [31:0] cnt_remaining,
  output logic        rep_skip
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] a1_q, a1_d;
  logic [31:0] a2_q, a2_d;
  logic [1:0]  opsize_q, opsize_d;
  logic        dflag_q, dflag_d;

  logic [31:0] cnt_eff;
  logic [31:0] step_in;
  logic [31:0] step_run;
  logic        cnt_zero;
  logic        cnt_multi;

  function automatic logic [31:0] step_addr(input logic [31:0] a,
                                            input logic [31:0] s,
                                            input logic        dec);
    return dec ? (a - s) : (a + s);
  endfunction

  assign cnt_eff   = addrmode ? count_in : {16'h0000, count_in[15:0]};
  assign step_in   = 32'd1 << opsize;
  assign step_run  = 32'd1 << opsize_q;
  assign cnt_zero  = (cnt_eff == 32'd0);
  assign cnt_multi = (cnt_eff >= 32'd2);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    a1_d          = a1_q;
    a2_d          = a2_q;
    opsize_d      = opsize_q;
    dflag_d       = dflag_q;
    mem_addr1     = addr1_in;
    mem_addr2     = addr2_in;
    iter_valid    = 1'b0;
    rep_stall     = 1'b0;
    rep_skip      = 1'b0;
    cnt_remaining = cnt_eff;

    case (state_q)
      IDLE: begin
        iter_valid    = valid_in & advance & ~(is_rep & cnt_zero);
        rep_skip      = valid_in & is_rep & cnt_zero;
        rep_stall     = valid_in & is_rep & cnt_multi;
        cnt_remaining = (is_rep && !cnt_zero) ? (cnt_eff - 32'd1) : cnt_eff;
        // Without advance the first iteration is simply re-presented next cycle.
        if (valid_in && is_rep && cnt_multi && advance) begin
          state_d  = RUN;
          cnt_d    = cnt_eff - 32'd1;
          a1_d     = step_addr(addr1_in, step_in, dflag);
          a2_d     = step_addr(addr2_in, step_in, dflag);
          opsize_d = opsize;
          dflag_d  = dflag;
        end
      end
      RUN: begin
        mem_addr1     = a1_q;
        mem_addr2     = a2_q;
        iter_valid    = advance;
        rep_stall     = (cnt_q > 32'd1);
        cnt_remaining = cnt_q - 32'd1;
        if (advance) begin
          cnt_d = cnt_q - 32'd1;
          a1_d  = step_addr(a1_q, step_run, dflag_q);
          a2_d  = step_addr(a2_q, step_run, dflag_q);
          if (cnt_q == 32'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d    = IDLE;
      cnt_d      = 32'd0;
      iter_valid = 1'b0;
      rep_stall  = 1'b0;
      rep_skip   = 1'b0;
    end

    if (clr) begin
      iter_valid = 1'b0;
      rep_stall  = 1'b0;
      rep_skip   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= 32'd0;
      a1_q     <= 32'd0;
      a2_q     <= 32'd0;
      opsize_q <= 2'd0;
      dflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      opsize_q <= opsize_d;
      dflag_q  <= dflag_d;
    end
  end

endmodule

// File: tb/tb_rep_iter_ctrl.sv
// Directed-vector bench for rep_iter_ctrl: the driver pushes the hand-computed
// per-cycle response, a negedge monitor pops and compares it.
module tb_rep_iter_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        valid_in;
  logic        is_rep;
  logic [31:0] count_in;
  logic        addrmode;
  logic [31:0] addr1_in;
  logic [31:0] addr2_in;
  logic [1:0]  opsize;
  logic        dflag;
  logic        advance;
  logic        flush;
  logic [31:0] mem_addr1;
  logic [31:0] mem_addr2;
  logic        iter_valid;
  logic        rep_stall;
  logic [31:0] cnt_remaining;
  logic        rep_skip;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        ctl_only;
    logic        iv;
    logic        st;
    logic        sk;
    logic [31:0] cr;
    logic [31:0] m1;
    logic [31:0] m2;
  } exp_t;

  localparam int EW = $bits(exp_t);
  logic [EW-1:0] exp_q[$];
  string         name_q[$];

  rep_iter_ctrl dut (
    .clk           (clk),
    .clr           (clr),
    .valid_in      (valid_in),
    .is_rep        (is_rep),
    .count_in      (count_in),
    .addrmode      (addrmode),
    .addr1_in      (addr1_in),
    .addr2_in      (addr2_in),
    .opsize        (opsize),
    .dflag         (dflag),
    .advance       (advance),
    .flush         (flush),
    .mem_addr1     (mem_addr1),
    .mem_addr2     (mem_addr2),
    .iter_valid    (iter_valid),
    .rep_stall     (rep_stall),
    .cnt_remaining (cnt_remaining),
    .rep_skip      (rep_skip)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Driver tasks
  task automatic set_instr(input logic v, input logic rep, input logic [31:0] cnt,
                           input logic am, input logic [31:0] a1, input logic [31:0] a2,
                           input logic [1:0] os, input logic df);
    valid_in = v;
    is_rep   = rep;
    count_in = cnt;
    addrmode = am;
    addr1_in = a1;
    addr2_in = a2;
    opsize   = os;
    dflag    = df;
  endtask

  task automatic push_exp(input string name, input logic ctl, input logic iv,
                          input logic st, input logic sk, input logic [31:0] cr,
                          input logic [31:0] m1, input logic [31:0] m2);
    exp_t e;
    e.ctl_only = ctl;
    e.iv = iv;
    e.st = st;
    e.sk = sk;
    e.cr = cr;
    e.m1 = m1;
    e.m2 = m2;
    exp_q.push_back(EW'(e));
    name_q.push_back(name);
  endtask

  // One cycle with clr low; inputs change just after the rising edge.
  task automatic step(input string name, input logic adv, input logic fl,
                      input logic iv, input logic st, input logic sk,
                      input logic [31:0] cr, input logic [31:0] m1, input logic [31:0] m2);
    clr     = 1'b0;
    advance = adv;
    flush   = fl;
    push_exp(name, 1'b0, iv, st, sk, cr, m1, m2);
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cycle(input string name);
    clr     = 1'b1;
    advance = 1'b1;
    flush   = 1'b0;
    push_exp(name, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // No instruction present: proves the block is back in IDLE (RUN would issue).
  task automatic idle_check(input string name);
    set_instr(1'b0, 1'b0, 32'h0000_0005, 1'b1, 32'hAAAA_0000, 32'hBBBB_0000, 2'd0, 1'b0);
    step(name, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5, 32'hAAAA_0000, 32'hBBBB_0000);
  endtask

  task automatic check_reg(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      logic  bad;
      e  = exp_t'(exp_q.pop_front());
      nm = name_q.pop_front();
      n_tests++;
      bad = ({iter_valid, rep_stall, rep_skip} !== {e.iv, e.st, e.sk});
      if (!e.ctl_only)
        bad = bad || (cnt_remaining !== e.cr) || (mem_addr1 !== e.m1) || (mem_addr2 !== e.m2);
      if (bad) begin
        n_fail++;
        if (e.ctl_only)
          $display("FAIL %s: got iv=%b st=%b sk=%b expected iv=%b st=%b sk=%b",
                   nm, iter_valid, rep_stall, rep_skip, e.iv, e.st, e.sk);
        else
          $display("FAIL %s: got iv=%b st=%b sk=%b cr=%h a1=%h a2=%h expected iv=%b st=%b sk=%b cr=%h a1=%h a2=%h",
                   nm, iter_valid, rep_stall, rep_skip, cnt_remaining, mem_addr1, mem_addr2,
                   e.iv, e.st, e.sk, e.cr, e.m1, e.m2);
      end
    end
  end

  initial begin
    set_instr(1'b1, 1'b1, 32'd5, 1'b1, 32'h100, 32'h200, 2'd2, 1'b0);
    clr = 1'b1; advance = 1'b1; flush = 1'b0;
    @(posedge clk);
    #1;
    clr_cycle("reset_ctl0");
    clr_cycle("reset_ctl1");
    check_reg("reset_cnt", dut.cnt_q, 32'd0);

    // Pass-through of a non-REP instruction
    set_instr(1'b1, 1'b0, 32'd7, 1'b1, 32'h1000, 32'h1100, 2'd2, 1'b0);
    step("pass", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd7, 32'h1000, 32'h1100);
    idle_check("pass_idle");

    // REP MOVSD count 3; inputs scrambled in RUN must be ignored
    set_instr(1'b1, 1'b1, 32'd3, 1'b1, 32'h2000, 32'h3000, 2'd2, 1'b0);
    step("movsd_i0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd2, 32'h2000, 32'h3000);
    set_instr(1'b1, 1'b0, 32'd99, 1'b0, 32'hDEAD_0000, 32'hBEEF_0000, 2'd0, 1'b1);
    step("movsd_i1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1, 32'h2004, 32'h3004);
    step("movsd_i2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h2008, 32'h3008);
    idle_check("movsd_idle");

    // Decrement with byte step, wrapping below zero
    set_instr(1'b1, 1'b1, 32'd2, 1'b1, 32'h0, 32'h10, 2'd0, 1'b1);
    step("wrap_i0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1, 32'h0, 32'h10);
    step("wrap_i1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'hF);
    idle_check("wrap_idle");

    // Count zero, 32-bit and masked 16-bit
    set_instr(1'b1, 1'b1, 32'd0, 1'b1, 32'h4000, 32'h5000, 2'd1, 1'b0);
    step("skip32", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h4000, 32'h5000);
    set_instr(1'b1, 1'b1, 32'h0001_0000, 1'b0, 32'h4000, 32'h5000, 2'd1, 1'b0);
    step("skip16", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h4000, 32'h5000);
    idle_check("skip_idle");

    // 16-bit mode: 0x00010002 gives exactly two iterations
    set_instr(1'b1, 1'b1, 32'h0001_0002, 1'b0, 32'h6000, 32'h7000, 2'd1, 1'b0);
    step("cx_i0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1, 32'h6000, 32'h7000);
    step("cx_i1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h6002, 32'h7002);
    idle_check("cx_idle");

    // First iteration held in IDLE by advance low, then a two-iteration run
    set_instr(1'b1, 1'b1, 32'd2, 1'b1, 32'hC000, 32'hD000, 2'd3, 1'b0);
    step("hold_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1, 32'hC000, 32'hD000);
    step("hold_i0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1, 32'hC000, 32'hD000);
    step("hold_i1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'hC008, 32'hD008);
    idle_check("hold_end");

    // Stall mid-RUN: count 4, advance low in cycle 2
    set_instr(1'b1, 1'b1, 32'd4, 1'b1, 32'h8000, 32'h9000, 2'd2, 1'b0);
    step("stall_c1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd3, 32'h8000, 32'h9000);
    step("stall_c2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 32'h8004, 32'h9004);
    step("stall_c3", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd2, 32'h8004, 32'h9004);
    step("stall_c4", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1, 32'h8008, 32'h9008);
    step("stall_c5", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h800C, 32'h900C);
    idle_check("stall_idle");

    // Flush on the second iteration of count 5
    set_instr(1'b1, 1'b1, 32'd5, 1'b1, 32'hA000, 32'hB000, 2'd2, 1'b0);
    step("flush_i0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd4, 32'hA000, 32'hB000);
    step("flush_i1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'hA004, 32'hB004);
    check_reg("flush_cnt", dut.cnt_q, 32'd0);
    idle_check("flush_idle");

    // Same run aborted by clr
    set_instr(1'b1, 1'b1, 32'd5, 1'b1, 32'hA000, 32'hB000, 2'd2, 1'b0);
    step("clr_i0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd4, 32'hA000, 32'hB000);
    clr_cycle("clr_i1");
    check_reg("clr_cnt", dut.cnt_q, 32'd0);
    check_reg("clr_a1", dut.a1_q, 32'd0);
    check_reg("clr_a2", dut.a2_q, 32'd0);
    idle_check("clr_idle");

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
